mul_div_unit: RTL

Multi-cycle multiply/divide unit that executes the HI/LO operations selected by the 4-bit `mul_control` code the R-type decoder emits for mult/multu/div/divu. It sits beside the ALU in the execute stage and owns the architectural HI and LO registers. It also takes the mthi/mtlo writes and reports busy so the pipeline can stall mfhi/mflo and further HI/LO operations.

---
 rtl/mul_div_unit.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle HI/LO multiply/divide unit for mult/multu/div/divu.
// Owns the architectural HI and LO registers and takes mthi/mtlo writes while idle.
// Multiplication is radix-2 shift-add; division is restoring division on magnitudes.
// Signs are fixed up when the result is written back.
// Optional build macro MUL_FAST_EN: mult/multu complete with a single-cycle array
// multiply, so their result is written one cycle after accept. div/divu keep the
// 32-cycle path.
// Handshake: an operation is taken on a clock edge where the unit is idle, in_valid
// is high and mul_control is one-hot. While busy is high, in_valid, hi_we and lo_we
// are ignored, so the producer must hold the request until busy drops. done pulses
// for the single cycle in which hi/lo first show a new result.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mul_control,
    input  logic        in_valid,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [5:0]  cnt;
    logic        op_mul;     // latched: operation is a multiply
    logic        neg_q;      // negate product (mult) or quotient (div)
    logic        neg_r;      // negate remainder (div)
    logic [31:0] a_raw;      // original dividend, returned in HI on divide by zero
    logic [31:0] mcand;      // multiplicand magnitude or divisor magnitude
    logic [31:0] acc;        // upper product half / partial remainder
    logic [31:0] q;          // multiplier bits shifting out / quotient bits shifting in

`ifdef MUL_FAST_EN
    logic        op_smul;
    logic [31:0] b_raw;
    logic [63:0] fast_prod;
`endif

    logic        ctl_onehot;
    logic        accept;
    logic        last_iter;
    logic        in_signed;
    logic        in_mul;
    logic [31:0] mag_a_in;
    logic [31:0] mag_b_in;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] acc_step;
    logic [31:0] q_step;
    logic [63:0] mul_prod;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign ctl_onehot = (mul_control != 4'd0) && ((mul_control & (mul_control - 4'd1)) == 4'd0);
    assign accept     = (state == IDLE) && in_valid && ctl_onehot;
    assign in_signed  = mul_control[0] | mul_control[2];
    assign in_mul     = mul_control[0] | mul_control[1];
    assign mag_a_in   = (in_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign mag_b_in   = (in_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

`ifdef MUL_FAST_EN
    assign fast_prod = op_smul ? ($signed({{32{a_raw[31]}}, a_raw}) * $signed({{32{b_raw[31]}}, b_raw}))
                               : ({32'd0, a_raw} * {32'd0, b_raw});
    assign last_iter = (state == CALC) && (op_mul || (cnt == 6'd31));
`else
    assign last_iter = (state == CALC) && (cnt == 6'd31);
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and busy
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One shift-add or restore-subtract step on the working registers
    always_comb begin
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, mcand} : 33'd0);
        div_shift = {acc, q[31]};
        div_ge    = (div_shift >= {1'b0, mcand});
        if (op_mul) begin
            acc_step = mul_sum[32:1];
            q_step   = {mul_sum[0], q[31:1]};
        end else if (div_ge) begin
            acc_step = div_shift[31:0] - mcand;
            q_step   = {q[30:0], 1'b1};
        end else begin
            acc_step = div_shift[31:0];
            q_step   = {q[30:0], 1'b0};
        end
    end

    // Final HI/LO value including sign fix-up and divide-by-zero handling.
    // The signed-overflow case 0x80000000 / -1 falls out naturally: the magnitudes
    // divide to 0x80000000 rem 0, and both signs are negative, so nothing is negated.
    always_comb begin
        mul_prod = {acc_step, q_step};
        if (neg_q) begin
            mul_prod = ~mul_prod + 64'd1;
        end
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (op_mul) begin
`ifdef MUL_FAST_EN
            {res_hi, res_lo} = fast_prod;
`else
            {res_hi, res_lo} = mul_prod;
`endif
        end else if (mcand == 32'd0) begin
            res_hi = a_raw;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_lo = neg_q ? (~q_step + 32'd1) : q_step;
            res_hi = neg_r ? (~acc_step + 32'd1) : acc_step;
        end
    end

    // Operand latch at accept, then one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 6'd0;
            op_mul <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            a_raw  <= 32'd0;
            mcand  <= 32'd0;
            acc    <= 32'd0;
            q      <= 32'd0;
`ifdef MUL_FAST_EN
            op_smul <= 1'b0;
            b_raw   <= 32'd0;
`endif
        end else if (accept) begin
            cnt    <= 6'd0;
            op_mul <= in_mul;
            a_raw  <= src_a;
            acc    <= 32'd0;
`ifdef MUL_FAST_EN
            op_smul <= mul_control[0];
            b_raw   <= src_b;
`endif
            if (in_mul) begin
                mcand <= mag_a_in;
                q     <= mag_b_in;
                neg_q <= mul_control[0] & (src_a[31] ^ src_b[31]);
                neg_r <= 1'b0;
            end else begin
                mcand <= mag_b_in;
                q     <= mag_a_in;
                neg_q <= mul_control[2] & (src_a[31] ^ src_b[31]);
                neg_r <= mul_control[2] & src_a[31];
            end
        end else if (state == CALC) begin
            acc <= acc_step;
            q   <= q_step;
            cnt <= cnt + 6'd1;
        end
    end

    // Architectural HI/LO: mthi/mtlo while idle, result on the last iteration
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= 32'd0;
            lo   <= 32'd0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
            if (last_iter) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end
        end
    end

endmodule
